// File: rtl/reg_context_engine_pkg.sv
// Shared types and constants for the register-file context save/restore engine.
package reg_context_engine_pkg;

   // Sequencer states: save walks RF -> memory, restore walks memory -> RF.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SAVE_RD = 3'd1,
      SAVE_WR = 3'd2,
      RST_RD  = 3'd3,
      RST_WB  = 3'd4,
      DONE    = 3'd5
   } ctx_state_t;

   // Each register occupies one 32-bit word in the save area.
   localparam int unsigned WORD_BYTES = 4;

   // Width of byte addresses on the data-memory port.
   localparam int unsigned ADDR_W = 32;

endpackage

// File: rtl/reg_context_engine.sv
// Saves or restores registers FIRST_REG..LAST_REG of the CPU register file
// to/from a contiguous word area in data memory starting at base_addr.
// All outputs are decoded from registered state only.
module reg_context_engine
   import reg_context_engine_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int RADDR_W   = 5,
   parameter int FIRST_REG = 1,
   parameter int LAST_REG  = 31
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               save_req,
   input  logic               restore_req,
   input  logic [ADDR_W-1:0]  base_addr,
   output logic               busy,
   output logic               done,
   output logic [RADDR_W-1:0] rf_read_reg,
   input  logic [DATA_W-1:0]  rf_read_data,
   output logic               rf_write_en,
   output logic [RADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0]  rf_write_data,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic               mem_re,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   input  logic               mem_ready
);

   localparam logic [RADDR_W-1:0] FIRST_IDX = RADDR_W'(FIRST_REG);
   localparam logic [RADDR_W-1:0] LAST_IDX  = RADDR_W'(LAST_REG);
   localparam logic [ADDR_W-1:0]  ADDR_STEP = ADDR_W'(WORD_BYTES);

   ctx_state_t         state_reg;
   ctx_state_t         state_next;
   logic [RADDR_W-1:0] r_reg;     // register currently being transferred
   logic [ADDR_W-1:0]  addr_reg;  // base + WORD_BYTES*(r - FIRST_REG), wraps mod 2^32
   logic [DATA_W-1:0]  data_reg;  // word in flight between RF and memory
   logic               is_last;
   logic               accept;

   assign is_last = (r_reg == LAST_IDX);
   // Requests are only looked at in IDLE; anything arriving while busy is dropped.
   assign accept  = (state_reg == IDLE) && (save_req || restore_req);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode; save takes priority over restore.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (save_req) begin
               state_next = SAVE_RD;
            end else if (restore_req) begin
               state_next = RST_RD;
            end
         end
         SAVE_RD: state_next = SAVE_WR;
         SAVE_WR: begin
            if (mem_ready) begin
               state_next = is_last ? DONE : SAVE_RD;
            end
         end
         RST_RD: begin
            if (mem_ready) begin
               state_next = RST_WB;
            end
         end
         RST_WB:  state_next = is_last ? DONE : RST_RD;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Register counter, address and data capture; address advances together with r.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg    <= '0;
         addr_reg <= '0;
         data_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  r_reg    <= FIRST_IDX;
                  addr_reg <= base_addr;
               end
            end
            SAVE_RD: begin
               data_reg <= rf_read_data;
            end
            SAVE_WR: begin
               if (mem_ready && !is_last) begin
                  r_reg    <= r_reg + 1'b1;
                  addr_reg <= addr_reg + ADDR_STEP;
               end
            end
            RST_RD: begin
               if (mem_ready) begin
                  data_reg <= mem_rdata;
               end
            end
            RST_WB: begin
               if (!is_last) begin
                  r_reg    <= r_reg + 1'b1;
                  addr_reg <= addr_reg + ADDR_STEP;
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode from registered state; idle values are all zero.
   always_comb begin
      busy          = (state_reg != IDLE);
      done          = 1'b0;
      rf_read_reg   = '0;
      rf_write_en   = 1'b0;
      rf_write_reg  = '0;
      rf_write_data = '0;
      mem_addr      = '0;
      mem_we        = 1'b0;
      mem_re        = 1'b0;
      mem_wdata     = '0;
      case (state_reg)
         SAVE_RD: begin
            rf_read_reg = r_reg;
         end
         SAVE_WR: begin
            mem_we    = 1'b1;
            mem_addr  = addr_reg;
            mem_wdata = data_reg;
         end
         RST_RD: begin
            mem_re   = 1'b1;
            mem_addr = addr_reg;
         end
         RST_WB: begin
            // Register 0 is hard-wired; never let a write reach it.
            rf_write_en   = (r_reg != '0);
            rf_write_reg  = r_reg;
            rf_write_data = data_reg;
         end
         DONE: begin
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/reg_context_engine.md
# reg_context_engine

Sequencer that saves or restores the CPU's general-purpose register file to or from data memory on request (interrupt entry/exit, context switch). It drives the register file's read port and write port from the far side, as an initiator, and issues word transfers to the data-memory port. Registers 1..31 are transferred; register 0 is never written.

## Interface
- DATA_W, 32, register and memory data width
- RADDR_W, 5, register index width
- FIRST_REG, 1, first register transferred
- LAST_REG, 31, last register transferred
- clk  in  1  system clock, all activity on rising edge
- rst  in  1  synchronous, active-high reset
- save_req  in  1  start save; sampled only in IDLE
- restore_req  in  1  start restore; sampled only in IDLE
- base_addr  in  32  byte address of save area; latched when a request is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE state
- rf_read_reg  out  RADDR_W  register-file read index
- rf_read_data  in  DATA_W  register-file read data for rf_read_reg
- rf_write_en  out  1  register-file write enable
- rf_write_reg  out  RADDR_W  register-file write index
- rf_write_data  out  DATA_W  register-file write data
- mem_addr  out  32  byte address
- mem_we  out  1  write request
- mem_re  out  1  read request
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid in the cycle mem_ready is high
- mem_ready  in  1  request complete this cycle

## Operation
- States: IDLE, SAVE_RD, SAVE_WR, RST_RD, RST_WB, DONE.
- IDLE: if save_req, go to SAVE_RD; else if restore_req, go to RST_RD. Save wins when both are high. On acceptance, latch base_addr and set reg counter r = FIRST_REG.
- SAVE_RD: rf_read_reg = r; capture rf_read_data at the closing edge; go to SAVE_WR.
- SAVE_WR: mem_we = 1, mem_addr = base + 4*(r-FIRST_REG), mem_wdata = captured value. Hold all of these until mem_ready. On mem_ready: if r == LAST_REG go to DONE, else r++ and go to SAVE_RD.
- RST_RD: mem_re = 1 at the same address formula. Hold until mem_ready; capture mem_rdata in that cycle; go to RST_WB.
- RST_WB: rf_write_en = 1 for exactly one cycle, rf_write_reg = r, rf_write_data = captured value. If r == LAST_REG go to DONE, else r++ and go to RST_RD.
- DONE: done = 1, busy = 1; go to IDLE next cycle.
- Address arithmetic is 32-bit modulo 2^32 and wraps silently.
- save_req/restore_req while busy: ignored, not queued.
- rf_write_en is never asserted with rf_write_reg = 0.
- mem_we and mem_re are never high together.

## Timing
- Reset values: busy, done, rf_write_en, mem_we, mem_re = 0. rf_read_reg, rf_write_reg, rf_write_data, mem_addr, mem_wdata = 0. State = IDLE.
- rst asserted in any state: next edge forces reset values. No further memory or register-file writes occur and no done pulse is issued; a partial transfer is abandoned.
- Request accepted at edge 0; first SAVE_RD or RST_RD cycle follows immediately.
- With mem_ready tied high, each register takes 2 cycles. 31 registers take cycles 1..62, and done is high in cycle 63.
- Each low cycle of mem_ready adds one cycle. Outputs stay stable while stalled.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds the state enum `ctx_state_t` and the constant WORD_BYTES = 4.
- No sub-module is needed: one FSM, one register counter, one address register, and one data capture register.

## Test plan
- Save, mem_ready = 1, RF model reg r = 0x1000_0000+r, base 0x0000_1000 -> 31 writes, mem_addr = 0x1000+4*(r-1), data 0x1000_0000+r, done in cycle 63, busy low in cycle 64.
- Restore, memory word at 0x2000+4*(r-1) = 0xA500_0000+r -> rf_write_en pulses for r = 1..31 with matching data, never reg 0, done in cycle 63.
- Save with mem_ready held low 3 cycles during r = 5 -> mem_addr, mem_wdata, and mem_we stable for 4 cycles, exactly one write to 0x1010, done in cycle 66.
- save_req and restore_req both high in IDLE -> save performed. restore_req pulsed during busy -> ignored, state IDLE after done.
- rst at cycle 20 of a save -> next cycle all outputs 0, no further mem_we, no done.
- base_addr 0xFFFF_FFF8, save -> r = 1 at 0xFFFF_FFF8, r = 2 at 0xFFFF_FFFC, r = 3 at 0x0000_0000.
